// File: rtl/adder_seq_ctrl.sv
// Two-requester wide adder sequencer: round-robin grant, then one nibble per
// clock through a single shared 4-bit adder slice, result held until taken.

module adder_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module adder_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4*NIBBLES-1:0] req0_a,
  input  logic [4*NIBBLES-1:0] req0_b,
  input  logic                 req0_cin,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4*NIBBLES-1:0] req1_a,
  input  logic [4*NIBBLES-1:0] req1_b,
  input  logic                 req1_cin,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] res_sum,
  output logic                 res_cout,
  output logic                 res_id,
  output logic                 busy
);
  localparam int W = 4 * NIBBLES;
  localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           id_q, id_d;
  logic           last_q, last_d;

  logic           gnt0, gnt1;
  logic [3:0]     slice_a, slice_b, slice_sum;
  logic           slice_cout;

  // the one and only adder slice, fed by the current nibble index
  always_comb begin
    slice_a = a_q[4*idx_q +: 4];
    slice_b = b_q[4*idx_q +: 4];
  end

  adder_nibble u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          state_d = RUN;
          a_d     = gnt1 ? req1_a : req0_a;
          b_d     = gnt1 ? req1_b : req0_b;
          carry_d = gnt1 ? req1_cin : req0_cin;
          id_d    = gnt1;
          last_d  = gnt1;
          idx_d   = 3'd0;
        end
      end
      RUN: begin
        sum_d[4*idx_q +: 4] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + 3'd1;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // on a tie, last_q points at the previous winner, so the other side wins
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
    req0_ready = gnt0;
    req1_ready = gnt1;
    res_valid  = (state_q == DONE);
    busy       = (state_q != IDLE);
    res_sum    = sum_q;
    res_cout   = carry_q;
    res_id     = id_q;
  end

endmodule
